// File: rtl/i2c_master_controller.sv
// i2c_master_controller: single-byte I2C master (START, addr+R/W, ACK, one byte, STOP).
// Ports: start/rw/addr/wdata in; rdata/busy/done/ack_err out; sda/scl open-drain inout.
// Optional macro I2C_CLK_STRETCH_EN: slave clock stretching honoured during the SCL-release phase.
module i2c_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_RNACK,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ack_err_q, ack_err_d;

  logic       tick;
  logic       hold;
  logic       sda_in;
  logic       sda_low;
  logic       scl_low;
  logic [7:0] addr_byte;

  assign sda_in    = sda;
  assign addr_byte = {addr_q, rw_q};
  assign tick      = (div_q == DIV_MAX);

`ifdef I2C_CLK_STRETCH_EN
  logic scl_in;
  assign scl_in = scl;
  // Slave holding SCL low while we release it freezes the bit.
  assign hold = (state_q != S_IDLE) && (phase_q == 2'd1) && !scl_in;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;

    if (state_q == S_IDLE) begin
      div_d   = '0;
      phase_d = 2'd0;
      bit_d   = 3'd7;
      if (start) begin
        state_d   = S_START;
        rw_d      = rw;
        addr_d    = addr;
        wdata_d   = wdata;
        rdata_d   = 8'h00;
        ack_err_d = 1'b0;
      end
    end else if (hold) begin
      div_d = '0;
    end else if (!tick) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d   = '0;
      phase_d = phase_q + 2'd1;

      // end of P2: SCL high, bus is stable
      if (phase_q == 2'd2) begin
        unique case (state_q)
          S_AACK, S_WACK: if (sda_in) ack_err_d = 1'b1;
          S_RDATA:        rdata_d = {rdata_q[6:0], sda_in};
          default: ;
        endcase
      end

      // end of P3: advance to next bit
      if (phase_q == 2'd3) begin
        unique case (state_q)
          S_START: begin
            state_d = S_ADDR;
            bit_d   = 3'd7;
          end
          S_ADDR: begin
            if (bit_q == 3'd0) state_d = S_AACK;
            else               bit_d = bit_q - 3'd1;
          end
          S_AACK: begin
            bit_d = 3'd7;
            if (ack_err_q)  state_d = S_STOP;
            else if (rw_q)  state_d = S_RDATA;
            else            state_d = S_WDATA;
          end
          S_WDATA: begin
            if (bit_q == 3'd0) state_d = S_WACK;
            else               bit_d = bit_q - 3'd1;
          end
          S_RDATA: begin
            if (bit_q == 3'd0) state_d = S_RNACK;
            else               bit_d = bit_q - 3'd1;
          end
          S_WACK:  state_d = S_STOP;
          S_RNACK: state_d = S_STOP;
          S_STOP:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Line drive is decoded from registered state, so a reset
  // releases both lines on the same edge.
  always_comb begin
    sda_low = 1'b0;
    scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);
    unique case (state_q)
      S_IDLE: scl_low = 1'b0;
      S_START: begin
        sda_low = phase_q[1];
        scl_low = (phase_q == 2'd3);
      end
      S_ADDR:  sda_low = !addr_byte[bit_q];
      S_WDATA: sda_low = !wdata_q[bit_q];
      S_STOP: begin
        sda_low = !phase_q[1];
        scl_low = (phase_q == 2'd0);
      end
      default: ;
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd7;
      rw_q      <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign rdata   = rdata_q;
  assign ack_err = ack_err_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_STOP) && (phase_q == 2'd3) && tick;

endmodule

// File: tb/tb_i2c_master_controller.sv
// tb_i2c_master_controller: random + directed bench for i2c_master_controller.
// A bus-level slave model at address 0x2A logs bytes, START/STOP and the master ACK bit.
module tb_i2c_master_controller;

  localparam int CD = 4;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  wire        sda;
  wire        scl;

  logic s_sda_low = 1'b0;
  logic s_scl_low = 1'b0;

  pullup (sda);
  pullup (scl);
  assign sda = (s_sda_low && rst_n) ? 1'b0 : 1'bz;
  assign scl = (s_scl_low && rst_n) ? 1'b0 : 1'bz;

  i2c_master_controller #(.CLK_DIV(CD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .sda     (sda),
    .scl     (scl)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [7:0] rd_byte = 8'h00;
  int         stretch_len = 0;
  logic       sda_p = 1'b1;
  logic       scl_p = 1'b1;
  int         bitn = 0;
  int         nbyte = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         st_cnt = 0;
  logic [7:0] sh = 8'h00;
  logic       match = 1'b0;
  logic       rd = 1'b0;
  logic       m_nack = 1'b0;
  logic [7:0] bus_q[$];

  always @(negedge clk) begin
    sda_p <= sda;
    scl_p <= scl;
    if (!rst_n) begin
      bitn      <= 0;
      nbyte     <= 0;
      match     <= 1'b0;
      rd        <= 1'b0;
      s_sda_low <= 1'b0;
      s_scl_low <= 1'b0;
      st_cnt    <= 0;
    end else begin
      if (st_cnt > 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1) s_scl_low <= 1'b0;
      end
      if (scl_p && scl && sda_p && !sda) begin
        n_start   <= n_start + 1;
        bitn      <= 0;
        nbyte     <= 0;
        match     <= 1'b0;
        rd        <= 1'b0;
        m_nack    <= 1'b0;
        s_sda_low <= 1'b0;
      end else if (scl_p && scl && !sda_p && sda) begin
        n_stop <= n_stop + 1;
      end else if (!scl_p && scl) begin
        if (bitn < 8) sh <= {sh[6:0], sda};
        else if (nbyte == 1 && rd) m_nack <= sda;
        bitn <= bitn + 1;
      end else if (scl_p && !scl) begin
        if (bitn == 8) begin
          bus_q.push_back(sh);
          if (nbyte == 0) begin
            match     <= (sh[7:1] == SLV);
            rd        <= sh[0];
            s_sda_low <= (sh[7:1] == SLV);
          end else begin
            s_sda_low <= match && !rd;
          end
        end else if (bitn == 9) begin
          bitn      <= 0;
          nbyte     <= nbyte + 1;
          s_sda_low <= match && rd && (nbyte == 0) && !rd_byte[7];
          if (nbyte == 0 && match && stretch_len > 0) begin
            s_scl_low <= 1'b1;
            st_cnt    <= stretch_len;
          end
        end else if (bitn >= 1 && bitn < 8 && match && rd && nbyte == 1) begin
          s_sda_low <= !rd_byte[3'(7 - bitn)];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; expectations come from the protocol rules:
  // slave at SLV ACKs address and write data, others stay silent.
  task automatic run(input logic r, input logic [6:0] a,
                     input logic [7:0] w, input logic [7:0] rb,
                     input int dup, input int stretch);
    int   qb, s0, p0, cyc, exp_cyc;
    logic seen, ok;
    qb      = bus_q.size();
    s0      = n_start;
    p0      = n_stop;
    rd_byte = rb;
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; wdata = w;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = (dup > 0 && i == dup);
      rw    = ~r;
      addr  = start ? (a ^ 7'h3F) : ~a;
      wdata = ~w;
      if (busy) cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    ok      = (a == SLV);
    exp_cyc = (ok ? 80 : 44) * CD;
    check("done_seen", 32'(seen), 32'd1);
    if (stretch == 0)
      check("busy_cycles", cyc, exp_cyc);
    else
      check("busy_stretch",
            32'(cyc >= exp_cyc + stretch - 2*CD - 2 &&
                cyc <= exp_cyc + stretch - 2*CD + 2), 32'd1);
    check("ack_err", 32'(ack_err), 32'(!ok));
    check("n_bytes", bus_q.size() - qb, ok ? 2 : 1);
    if (bus_q.size() > qb)
      check("addr_byte", 32'(bus_q[qb]), 32'({a, r}));
    if (ok && bus_q.size() > qb + 1)
      check("data_byte", 32'(bus_q[qb+1]), 32'(r ? rb : w));
    if (ok && r) begin
      check("rdata", 32'(rdata), 32'(rb));
      check("master_nack", 32'(m_nack), 32'd1);
    end
    check("starts", n_start - s0, 1);
    check("stops", n_stop - p0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_scl", 32'(scl), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b0, SLV, 8'h5A, 8'h00, 0, 0);
    run(1'b1, SLV, 8'h00, 8'hCC, 0, 0);
    run(1'b0, 7'h15, 8'hA5, 8'h00, 0, 0);
    run(1'b0, SLV, 8'h81, 8'h00, 10, 0);

    // start during the done cycle is dropped
    start = 1'b1; rw = 1'b0; addr = SLV; wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("start_on_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("still_idle", 32'(busy), 32'd0);

    // reset in the middle of a read data byte
    rd_byte = 8'hCC;
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = SLV; wdata = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (13*4*CD) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_sda", 32'(sda), 32'd1);
    check("mid_rst_scl", 32'(scl), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b1, SLV, 8'h00, 8'h96, 0, 0);

    for (int k = 0; k < 10; k++) begin
      logic [6:0] a;
      int         dup;
      a   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      dup = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 150)) : 0;
      run(1'($urandom), a, 8'($urandom), 8'($urandom), dup, 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    stretch_len = 50;
    run(1'b1, SLV, 8'h00, 8'h3C, 0, 50);
    stretch_len = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
